ahb_bus_arbiter: RTL and testbench
==================================

Name: ahb_bus_arbiter

Overview:
- Round-robin arbiter and address/write-data multiplexer for the simplified AHB bus (haddr, hwdata, hwrite, htrans, hresp, hrdata).
- Lets NUM_MASTERS master modules share one slave-side bus in the chip-level netlist.
- Issues per-master grants and tracks the address-phase owner (hmaster) and data-phase owner (hmaster_d).
- Routes the owner's address/control and the data-phase owner's hwdata to the shared bus.
- Optional lock and per-tenure beat limit.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..16).
- MW, $clog2(NUM_MASTERS), master index width (derived, not overridden).
- MAX_BEATS, 8, transfers per tenure before the owner is preempted; 0 disables preemption.
- DEFAULT_MASTER, 0, park master when nobody requests.

Ports:
- hclk  in  1  bus clock
- reset  in  1  synchronous, active-high reset
- hready  in  1  slave ready; 1 = current transfer phase completes this edge
- hbusreq  in  NUM_MASTERS  per-master bus request
- hlock  in  NUM_MASTERS  per-master locked-transfer request
- m_haddr  in  NUM_MASTERS*32  packed master addresses, master i at [32i+:32]
- m_htrans  in  NUM_MASTERS*2  packed transfer types
- m_hwrite  in  NUM_MASTERS  per-master write flag
- m_hwdata  in  NUM_MASTERS*32  packed write data
- hgrant  out  NUM_MASTERS  registered one-hot (or all-zero) grant
- hmaster  out  MW  registered address-phase owner
- hmaster_d  out  MW  registered data-phase owner
- haddr  out  32  bus address
- htrans  out  2  bus transfer type
- hwrite  out  1  bus write flag
- hwdata  out  32  bus write data

Behaviour:
- Encoding: htrans 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- Reset (reset=1 at hclk edge): hmaster=hmaster_d=DEFAULT_MASTER; hgrant=one-hot DEFAULT_MASTER; beat count=0; rr pointer=DEFAULT_MASTER.
- While reset=1, htrans output is forced to 00. Reset mid-burst abandons the tenure with no completion.
- Address mux: haddr/htrans/hwrite come combinationally from master hmaster.
- Data mux: hwdata comes combinationally from master hmaster_d.
- hready=0: all registers hold (hmaster, hmaster_d, count, hgrant, pointer).
- hready=1 edge: hmaster_d <= hmaster, using the old hmaster value, so the data phase lags the address phase by exactly one cycle.
- Arbitration point: hready=1 AND owner's m_htrans==IDLE AND hlock[hmaster]==0.
- Ownership never changes mid-burst (NONSEQ/SEQ/BUSY).
- Winner search: first asserted hbusreq scanning hmaster+1, hmaster+2 … wrapping modulo NUM_MASTERS, with hmaster itself checked last.
- If the owner is the only requester, it keeps the bus.
- If no requests, hmaster <= DEFAULT_MASTER.
- On every arbitration point, next-cycle hgrant = one-hot(winner).
- Beat counter: cleared when hmaster changes value; otherwise +1 on each hready=1 edge with owner htrans in {NONSEQ, SEQ}; saturates at MAX_BEATS.
- Preemption: count==MAX_BEATS (MAX_BEATS≠0) AND another master's hbusreq=1 AND hlock[hmaster]==0 → hgrant <= all-zero.
  - hmaster is unchanged; the owner finishes its burst and drives IDLE, and the switch happens at the next arbitration point.
- Lock: hlock[hmaster]=1 suppresses both arbitration and preemption. The owner retains the bus even across IDLE cycles until hlock drops.
- Simultaneous: owner goes IDLE with hlock=0 while several others request → rr order picks exactly one. hgrant is never multi-hot.
- Owner drops hbusreq mid-burst: no effect until IDLE.
- Requests from non-granted masters never reach the bus outputs.
- Arbitration decision latency: one hclk edge. New owner's address appears on the cycle after the arbitration edge.

Test Plan:
- Reset with all hbusreq=0 → hmaster=0, hgrant=4'b0001, htrans=00. Release reset, no requests for 5 cycles → unchanged.
- hbusreq=4'b0110, master0 drives IDLE, hready=1 → next cycle hmaster=1, hgrant=0010, haddr=m_haddr[1].
  - Master1 does NONSEQ then IDLE → hmaster=2.
  - Master2 IDLE, master1 still requesting → hmaster=1.
- Master1 owns and issues NONSEQ A=0x100 with hwdata 0xDEADBEEF on the following cycle, hready toggling 1,0,1 → hmaster_d=1 exactly one accepted phase later; hwdata held while hready=0.
- MAX_BEATS=4: master3 runs an 8-beat SEQ burst while master0 requests → hgrant=0 after the 4th accepted beat, hmaster stays 3 until master3's IDLE, then hmaster=0, count=0.
- Same as above but hlock[3]=1 → hgrant stays 1000 through all 8 beats and 2 IDLE cycles. hlock drop + IDLE → hmaster=0.
- Assert reset mid-burst (master2 on SEQ beat 3) → next cycle hmaster=0, hmaster_d=0, hgrant=0001, count=0, htrans=00 during reset.

Source files
------------

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter with address/control and write-data muxing.
// Ports: hclk/reset/hready, per-master req/lock/bus fields, grant, owners, shared bus.
module ahb_bus_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int MAX_BEATS      = 8,
    parameter int DEFAULT_MASTER = 0,
    localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                      hclk,
    input  logic                      reset,
    input  logic                      hready,
    input  logic [NUM_MASTERS-1:0]    hbusreq,
    input  logic [NUM_MASTERS-1:0]    hlock,
    input  logic [NUM_MASTERS*32-1:0] m_haddr,
    input  logic [NUM_MASTERS*2-1:0]  m_htrans,
    input  logic [NUM_MASTERS-1:0]    m_hwrite,
    input  logic [NUM_MASTERS*32-1:0] m_hwdata,
    output logic [NUM_MASTERS-1:0]    hgrant,
    output logic [MW-1:0]             hmaster,
    output logic [MW-1:0]             hmaster_d,
    output logic [31:0]               haddr,
    output logic [1:0]                htrans,
    output logic                      hwrite,
    output logic [31:0]               hwdata
);

    localparam int CW = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;

    localparam logic [1:0] TR_IDLE = 2'b00;

    function automatic logic [NUM_MASTERS-1:0] onehot(input logic [MW-1:0] i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    // The address-phase owner doubles as the round-robin pointer:
    // the search always starts just after it.
    logic [MW-1:0]          amst_q, amst_d;
    logic [MW-1:0]          dmst_q, dmst_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;

    logic [1:0]    own_trans;
    logic          own_lock;
    logic          own_beat;
    logic          arb_pt;
    logic          others;
    logic          preempt;
    logic [MW-1:0] win;
    logic [MW-1:0] idx;
    logic          found;

    assign own_trans = m_htrans[{amst_q, 1'b0} +: 2];
    assign own_lock  = hlock[amst_q];
    assign own_beat  = own_trans[1];
    assign arb_pt    = hready && (own_trans == TR_IDLE) && !own_lock;
    assign others    = |(hbusreq & ~onehot(amst_q));
    assign preempt   = (MAX_BEATS != 0) && (cnt_q == CW'(MAX_BEATS))
                       && others && !own_lock;

    // Scan owner+1 .. owner+N; the owner itself comes last.
    always_comb begin
        win   = MW'(DEFAULT_MASTER);
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            idx = MW'((int'(amst_q) + i) % NUM_MASTERS);
            if (!found && hbusreq[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        amst_d = amst_q;
        dmst_d = dmst_q;
        cnt_d  = cnt_q;
        gnt_d  = gnt_q;
        if (hready) begin
            dmst_d = amst_q;
            if (arb_pt) begin
                amst_d = win;
                gnt_d  = onehot(win);
            end else if (preempt) begin
                // Owner keeps the bus until its burst ends at IDLE.
                gnt_d = '0;
            end
            if (amst_d != amst_q) begin
                cnt_d = '0;
            end else if (own_beat && (cnt_q < CW'(MAX_BEATS))) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (reset) begin
            amst_q <= MW'(DEFAULT_MASTER);
            dmst_q <= MW'(DEFAULT_MASTER);
            cnt_q  <= '0;
            gnt_q  <= onehot(MW'(DEFAULT_MASTER));
        end else begin
            amst_q <= amst_d;
            dmst_q <= dmst_d;
            cnt_q  <= cnt_d;
            gnt_q  <= gnt_d;
        end
    end

    assign hgrant    = gnt_q;
    assign hmaster   = amst_q;
    assign hmaster_d = dmst_q;
    assign haddr     = m_haddr[{amst_q, 5'b0} +: 32];
    assign htrans    = reset ? TR_IDLE : own_trans;
    assign hwrite    = m_hwrite[amst_q];
    assign hwdata    = m_hwdata[{dmst_q, 5'b0} +: 32];

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed bench for ahb_bus_arbiter (4 masters, 4-beat tenure limit).
// Checks grant/owner sequencing, muxing, preemption, lock and reset.
module tb_ahb_bus_arbiter;

    localparam int N = 4;

    logic           hclk = 1'b0;
    logic           reset;
    logic           hready;
    logic [N-1:0]   hbusreq;
    logic [N-1:0]   hlock;
    logic [N*32-1:0] m_haddr;
    logic [N*2-1:0] m_htrans;
    logic [N-1:0]   m_hwrite;
    logic [N*32-1:0] m_hwdata;
    logic [N-1:0]   hgrant;
    logic [1:0]     hmaster;
    logic [1:0]     hmaster_d;
    logic [31:0]    haddr;
    logic [1:0]     htrans;
    logic           hwrite;
    logic [31:0]    hwdata;

    int checks = 0;
    int failures = 0;

    ahb_bus_arbiter #(
        .NUM_MASTERS(N),
        .MAX_BEATS(4),
        .DEFAULT_MASTER(0)
    ) dut (
        .hclk(hclk),
        .reset(reset),
        .hready(hready),
        .hbusreq(hbusreq),
        .hlock(hlock),
        .m_haddr(m_haddr),
        .m_htrans(m_htrans),
        .m_hwrite(m_hwrite),
        .m_hwdata(m_hwdata),
        .hgrant(hgrant),
        .hmaster(hmaster),
        .hmaster_d(hmaster_d),
        .haddr(haddr),
        .htrans(htrans),
        .hwrite(hwrite),
        .hwdata(hwdata)
    );

    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic setm(input int i, input logic [31:0] a,
                        input logic [1:0] t, input logic w,
                        input logic [31:0] d);
        m_haddr[32*i +: 32]  = a;
        m_htrans[2*i +: 2]   = t;
        m_hwrite[i]          = w;
        m_hwdata[32*i +: 32] = d;
    endtask

    task automatic cyc();
        @(posedge hclk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        hready   = 1'b1;
        hbusreq  = '0;
        hlock    = '0;
        m_haddr  = '0;
        m_htrans = '0;
        m_hwrite = '0;
        m_hwdata = '0;
        setm(0, 32'h0000_0000, 2'b10, 1'b0, 32'h0000_0000);
        setm(1, 32'h0000_0100, 2'b00, 1'b0, 32'h1111_1111);
        setm(2, 32'h0000_0200, 2'b00, 1'b0, 32'h2222_2222);
        setm(3, 32'h0000_0BAD, 2'b00, 1'b0, 32'h3333_3333);

        // reset
        cyc();
        cyc();
        chk("rst_hmaster", 32'(hmaster), 0);
        chk("rst_hmaster_d", 32'(hmaster_d), 0);
        chk("rst_hgrant", 32'(hgrant), 32'b0001);
        chk("rst_htrans", 32'(htrans), 0);
        reset = 1'b0;
        setm(0, 32'h0000_0000, 2'b00, 1'b0, 32'h0000_0000);
        for (int i = 0; i < 5; i++) cyc();
        chk("idle_hmaster", 32'(hmaster), 0);
        chk("idle_hgrant", 32'(hgrant), 32'b0001);

        // rr handover 0 -> 1
        hbusreq = 4'b0110;
        cyc();
        chk("rr1_hmaster", 32'(hmaster), 1);
        chk("rr1_hgrant", 32'(hgrant), 32'b0010);
        chk("rr1_haddr", haddr, 32'h0000_0100);
        chk("rr1_hmaster_d", 32'(hmaster_d), 0);

        // master1 NONSEQ with hready stall
        setm(1, 32'h0000_0100, 2'b10, 1'b1, 32'h1111_1111);
        setm(3, 32'h0000_0BAD, 2'b10, 1'b0, 32'h3333_3333);
        hready = 1'b0;
        #1;
        chk("ns_haddr", haddr, 32'h0000_0100);
        chk("ns_htrans", 32'(htrans), 32'b10);
        chk("ns_hwrite", 32'(hwrite), 1);
        cyc();
        chk("stall_hmaster_d", 32'(hmaster_d), 0);
        chk("stall_hmaster", 32'(hmaster), 1);
        hready = 1'b1;
        cyc();
        chk("acc_hmaster_d", 32'(hmaster_d), 1);
        chk("acc_hmaster", 32'(hmaster), 1);

        // data phase with stall
        setm(1, 32'h0000_0104, 2'b00, 1'b0, 32'hDEAD_BEEF);
        hready = 1'b0;
        cyc();
        chk("dp_hwdata0", hwdata, 32'hDEAD_BEEF);
        cyc();
        chk("dp_hwdata1", hwdata, 32'hDEAD_BEEF);
        chk("dp_hold_hmaster", 32'(hmaster), 1);
        hready = 1'b1;
        cyc();
        chk("rr2_hmaster", 32'(hmaster), 2);
        chk("rr2_hgrant", 32'(hgrant), 32'b0100);
        chk("rr2_hmaster_d", 32'(hmaster_d), 1);
        chk("rr2_hwdata", hwdata, 32'hDEAD_BEEF);
        cyc();
        chk("rr3_hmaster", 32'(hmaster), 1);
        chk("rr3_haddr", haddr, 32'h0000_0104);
        setm(3, 32'h0000_0300, 2'b00, 1'b0, 32'h3333_3333);

        // preemption of master3 by master0
        hbusreq = 4'b1000;
        cyc();
        chk("pre_hmaster", 32'(hmaster), 3);
        chk("pre_hgrant", 32'(hgrant), 32'b1000);
        hbusreq = 4'b1001;
        for (int k = 1; k <= 8; k++) begin
            setm(3, 32'h300 + 32'(4 * k), (k == 1) ? 2'b10 : 2'b11,
                 1'b1, 32'h3333_3333);
            cyc();
            if (k == 2) chk("pre_b2_hgrant", 32'(hgrant), 32'b1000);
            if (k == 6) begin
                chk("pre_b6_hgrant", 32'(hgrant), 0);
                chk("pre_b6_hmaster", 32'(hmaster), 3);
            end
            if (k == 8) begin
                chk("pre_b8_hgrant", 32'(hgrant), 0);
                chk("pre_b8_hmaster", 32'(hmaster), 3);
            end
        end
        setm(3, 32'h0000_0300, 2'b00, 1'b0, 32'h3333_3333);
        cyc();
        chk("pre_sw_hmaster", 32'(hmaster), 0);
        chk("pre_sw_hgrant", 32'(hgrant), 32'b0001);
        // fresh count: four beats without preemption
        for (int k = 1; k <= 4; k++) begin
            setm(0, 32'(16 * k), (k == 1) ? 2'b10 : 2'b11, 1'b0, 0);
            cyc();
        end
        chk("cnt0_hgrant", 32'(hgrant), 32'b0001);
        chk("cnt0_hmaster", 32'(hmaster), 0);

        // locked burst by master3
        setm(0, 32'h0000_0000, 2'b00, 1'b0, 0);
        hbusreq = 4'b1000;
        hlock   = 4'b1000;
        cyc();
        chk("lk_hmaster", 32'(hmaster), 3);
        hbusreq = 4'b1001;
        for (int k = 1; k <= 8; k++) begin
            setm(3, 32'h300 + 32'(4 * k), (k == 1) ? 2'b10 : 2'b11,
                 1'b1, 32'h3333_3333);
            cyc();
            if (k == 6) chk("lk_b6_hgrant", 32'(hgrant), 32'b1000);
            if (k == 8) chk("lk_b8_hgrant", 32'(hgrant), 32'b1000);
        end
        setm(3, 32'h0000_0300, 2'b00, 1'b0, 32'h3333_3333);
        for (int k = 0; k < 2; k++) begin
            cyc();
            chk("lk_idle_hgrant", 32'(hgrant), 32'b1000);
            chk("lk_idle_hmaster", 32'(hmaster), 3);
        end
        hlock = 4'b0000;
        cyc();
        chk("lk_rel_hmaster", 32'(hmaster), 0);
        chk("lk_rel_hgrant", 32'(hgrant), 32'b0001);

        // reset mid-burst of master2
        hbusreq = 4'b0100;
        cyc();
        chk("mb_hmaster", 32'(hmaster), 2);
        for (int k = 1; k <= 2; k++) begin
            setm(2, 32'h200 + 32'(4 * k), (k == 1) ? 2'b10 : 2'b11,
                 1'b0, 32'h2222_2222);
            cyc();
        end
        chk("mb_hmaster_d", 32'(hmaster_d), 2);
        setm(2, 32'h0000_020C, 2'b11, 1'b0, 32'h2222_2222);
        reset = 1'b1;
        #1;
        chk("mb_rst_htrans0", 32'(htrans), 0);
        cyc();
        chk("mb_rst_hmaster", 32'(hmaster), 0);
        chk("mb_rst_hmaster_d", 32'(hmaster_d), 0);
        chk("mb_rst_hgrant", 32'(hgrant), 32'b0001);
        chk("mb_rst_htrans1", 32'(htrans), 0);
        reset   = 1'b0;
        hbusreq = 4'b0000;
        setm(2, 32'h0000_0200, 2'b00, 1'b0, 32'h2222_2222);
        cyc();
        chk("post_hmaster", 32'(hmaster), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
